// File: rtl/aln_result_packer.sv
// rtl/aln_result_packer.sv - buffers one traceback column stream and replays it as a framed byte stream
module aln_result_packer #(
    parameter int MAX_COLS    = 64,
    parameter int SCORE_WIDTH = 8,
    parameter int REVERSE     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [2:0]             in_q_sym,
    input  logic [2:0]             in_d_sym,
    input  logic [SCORE_WIDTH-1:0] in_score,
    output logic                   pk_ready,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   ovf
);
    localparam int         AW      = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
    localparam logic [6:0] CNT_MAX = 7'(MAX_COLS);

    typedef enum logic [2:0] {IDLE, COLLECT, HDR_SCORE, HDR_LEN, DRAIN} state_t;
    state_t state, state_next;

    logic [6:0]             mem [MAX_COLS];
    logic [6:0]             cnt;
    logic [AW-1:0]          rd_idx;
    logic                   frame_ovf;
    logic [SCORE_WIDTH-1:0] score_q;

    logic          hs;
    logic          col_match;
    logic [6:0]    col_entry;
    logic          accept;
    logic          store;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_first;
    logic [AW-1:0] rd_step;
    logic [AW-1:0] rd_final;
    logic [AW-1:0] rd_next;

    assign hs        = out_valid && out_ready;
    assign col_match = !in_q_sym[2] && !in_d_sym[2] && (in_q_sym[1:0] == in_d_sym[1:0]);
    assign col_entry = {in_q_sym, in_d_sym, col_match};
    assign accept    = in_valid && ((state == IDLE) || (state == COLLECT));
    assign store     = accept && ((state == IDLE) || (cnt < CNT_MAX));
    // cnt may be stale from the previous frame while IDLE, so column 0 is addressed explicitly
    assign wr_idx    = (state == IDLE) ? '0 : cnt[AW-1:0];
    assign pk_ready  = (state == IDLE);

    assign rd_first = (REVERSE != 0) ? AW'(cnt - 7'd1) : '0;
    assign rd_final = (REVERSE != 0) ? '0 : AW'(cnt - 7'd1);
    assign rd_step  = (REVERSE != 0) ? (rd_idx - AW'(1)) : (rd_idx + AW'(1));
    assign rd_next  = (state == DRAIN) ? rd_step : rd_first;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (in_valid)         state_next = COLLECT;
            COLLECT:   if (!in_valid)        state_next = HDR_SCORE;
            HDR_SCORE: if (hs)               state_next = HDR_LEN;
            HDR_LEN:   if (hs)               state_next = DRAIN;
            DRAIN:     if (hs && out_last)   state_next = IDLE;
            default:                         state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_idx] <= col_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            rd_idx    <= '0;
            frame_ovf <= 1'b0;
            score_q   <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            if (accept) begin
                score_q <= in_score;
                if (state == IDLE) begin
                    cnt <= 7'd1;
                end else if (cnt < CNT_MAX) begin
                    cnt <= cnt + 7'd1;
                end else begin
                    frame_ovf <= 1'b1;
                    ovf       <= 1'b1;
                end
            end
            if (in_valid && !accept) begin
                ovf <= 1'b1;
            end

            // Output registers are loaded one byte ahead, so the next byte is ready right after each handshake
            case (state)
                COLLECT: begin
                    if (!in_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= 8'(score_q);
                        out_last  <= 1'b0;
                    end
                end
                HDR_SCORE: begin
                    if (hs) begin
                        out_data <= {frame_ovf, cnt};
                    end
                end
                HDR_LEN, DRAIN: begin
                    if (hs) begin
                        if ((state == DRAIN) && out_last) begin
                            out_valid <= 1'b0;
                            out_data  <= 8'h00;
                            out_last  <= 1'b0;
                            frame_ovf <= 1'b0;
                        end else begin
                            rd_idx   <= rd_next;
                            out_data <= {mem[rd_next], 1'b0};
                            out_last <= (rd_next == rd_final);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aln_result_packer.sv
// tb/tb_aln_result_packer.sv - directed bench for the alignment result packer
module tb_aln_result_packer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] in_q_sym = 3'b000;
    logic [2:0] in_d_sym = 3'b000;
    logic [7:0] in_score = 8'h00;
    logic       out_ready = 1'b0;
    logic       pk_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_last;
    logic       ovf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    aln_result_packer #(.MAX_COLS(64), .SCORE_WIDTH(8), .REVERSE(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_q_sym (in_q_sym),
        .in_d_sym (in_d_sym),
        .in_score (in_score),
        .pk_ready (pk_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .ovf      (ovf)
    );

    typedef struct {
        logic [2:0] q;
        logic [2:0] d;
        logic [7:0] score;
        logic [7:0] exp_col;
    } vec_t;

    vec_t       vecs[8];
    logic [2:0] col_q[$];
    logic [2:0] col_d[$];
    logic [7:0] got[$];
    logic       got_last[$];
    logic [7:0] exp_b[$];
    int         first_cyc;
    logic [5:0] rdy_pat = 6'b101001;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] score);
        for (int i = 0; i < col_q.size(); i++) begin
            @(negedge clk);
            if (i == 0) chk("pk_ready_at_start", pk_ready, 1);
            in_valid = 1'b1;
            in_q_sym = col_q[i];
            in_d_sym = col_d[i];
            in_score = score;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect(input int mode, input int inject, input int stop_after, input int budget);
        int         cyc = 0;
        int         k = 0;
        int         inj = 0;
        bit         done = 0;
        bit         stalled = 0;
        logic [7:0] pd = 8'h00;
        logic       pl = 1'b0;
        got.delete();
        got_last.delete();
        first_cyc = -1;
        while (!done && cyc < budget && !(stop_after > 0 && got.size() >= stop_after)) begin
            @(negedge clk);
            cyc++;
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            if (stalled) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, pd);
                chk("hold_last", out_last, pl);
            end
            if (inject != 0 && got.size() == 2 && inj < 3) begin
                out_ready = 1'b0;
                in_valid  = 1'b1;
                in_q_sym  = 3'b001;
                in_d_sym  = 3'b010;
                inj++;
                chk("busy_pk_ready", pk_ready, 0);
            end else begin
                in_valid  = 1'b0;
                out_ready = (mode == 0) ? 1'b1 : rdy_pat[k % 6];
                k++;
            end
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                got_last.push_back(out_last);
                if (out_last) done = 1;
            end
            stalled = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
        end
        if (stop_after == 0) chk("frame_done_in_budget", done, 1);
    endtask

    task automatic verify(input string tag);
        chk($sformatf("%s_nbytes", tag), got.size(), exp_b.size());
        for (int i = 0; i < got.size() && i < exp_b.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), got[i], exp_b[i]);
            chk($sformatf("%s_last%0d", tag, i), got_last[i], (i == exp_b.size() - 1));
        end
    endtask

    task automatic set_basic();
        col_q.delete();
        col_d.delete();
        col_q.push_back(3'b011); col_d.push_back(3'b011);
        col_q.push_back(3'b100); col_d.push_back(3'b010);
        col_q.push_back(3'b000); col_d.push_back(3'b000);
        exp_b.delete();
        exp_b.push_back(8'h05);
        exp_b.push_back(8'h03);
        exp_b.push_back(8'h02);
        exp_b.push_back(8'h88);
        exp_b.push_back(8'h6E);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{3'b000, 3'b000, 8'h00, 8'h02};
        vecs[1] = '{3'b011, 3'b011, 8'hFF, 8'h6E};
        vecs[2] = '{3'b001, 3'b010, 8'h7A, 8'h28};
        vecs[3] = '{3'b110, 3'b110, 8'h01, 8'hD8};
        vecs[4] = '{3'b010, 3'b110, 8'h80, 8'h58};
        vecs[5] = '{3'b101, 3'b001, 8'h3C, 8'hA4};
        vecs[6] = '{3'b010, 3'b010, 8'h05, 8'h4A};
        vecs[7] = '{3'b111, 3'b011, 8'hC3, 8'hEC};

        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_last", out_last, 0);
        chk("rst_pk_ready", pk_ready, 1);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            col_q.delete();
            col_d.delete();
            col_q.push_back(vecs[i].q);
            col_d.push_back(vecs[i].d);
            send(vecs[i].score);
            collect(0, 0, 0, 20);
            exp_b.delete();
            exp_b.push_back(vecs[i].score);
            exp_b.push_back(8'h01);
            exp_b.push_back(vecs[i].exp_col);
            verify($sformatf("vec%0d", i));
        end

        set_basic();
        send(8'h05);
        chk("latency_not_yet", out_valid, 0);
        collect(0, 0, 0, 20);
        chk("latency_first_byte", first_cyc, 1);
        verify("basic");

        set_basic();
        send(8'h05);
        collect(1, 0, 0, 60);
        verify("backpressure");

        col_q.delete();
        col_d.delete();
        for (int i = 0; i < 70; i++) begin
            col_q.push_back(3'b000);
            col_d.push_back(3'b000);
        end
        send(8'h11);
        collect(0, 0, 0, 200);
        exp_b.delete();
        exp_b.push_back(8'h11);
        exp_b.push_back(8'hC0);
        for (int i = 0; i < 64; i++) exp_b.push_back(8'h02);
        verify("overflow");
        chk("overflow_ovf", ovf, 1);

        set_basic();
        send(8'h05);
        collect(0, 0, 0, 20);
        verify("after_overflow");
        chk("ovf_sticky", ovf, 1);

        do_reset();
        rst = 1'b0;
        chk("drop_ovf_before", ovf, 0);
        set_basic();
        send(8'h05);
        collect(0, 1, 0, 60);
        verify("drop_busy");
        chk("drop_ovf_after", ovf, 1);
        @(negedge clk);
        chk("drop_pk_ready_after", pk_ready, 1);

        set_basic();
        send(8'h05);
        collect(0, 0, 4, 60);
        chk("mid_rst_bytes_seen", got.size(), 4);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_pk_ready", pk_ready, 1);
        chk("mid_rst_ovf", ovf, 0);
        rst = 1'b0;
        set_basic();
        send(8'h05);
        collect(0, 0, 0, 20);
        verify("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/aln_result_packer.md
# aln_result_packer

Downstream consumer of the alignment core's traceback stream. It buffers one complete aligned-symbol stream as it is emitted and annotates each column with a match flag. It then replays the alignment to the host as a byte-wide framed stream under valid/ready backpressure: score byte, length byte, then one byte per column. By default it restores start-to-end order, since traceback emits end-to-start.

## Interface
- MAX_COLS, 64: column buffer depth; the longest legal alignment is 32 + 32 letters.
- SCORE_WIDTH, 8: width of the score from the core. It must be ≤ 8.
- REVERSE, 1: 1 emits columns in reverse arrival order (LIFO); 0 emits in arrival order (FIFO).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  the core's output_valid. High for consecutive cycles, one column per cycle.
- in_q_sym  in  3  query column symbol: [2] = gap, [1:0] = letter (A=00, G=01, T=10, C=11).
- in_d_sym  in  3  database column symbol, same encoding.
- in_score  in  SCORE_WIDTH  alignment score, stable while in_valid is high.
- pk_ready  out  1  high only in IDLE. Upstream gates start with it.
- out_data  out  8  framed output byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  host accepts the byte when out_valid && out_ready.
- out_last  out  1  marks the final byte of a frame.
- ovf  out  1  sticky error flag, cleared only by rst.

## Operation
- States: IDLE, COLLECT, HDR_SCORE, HDR_LEN, DRAIN.
- IDLE:
  - in_valid=1: write column 0, latch score, cnt←1, go to COLLECT.
- COLLECT:
  - in_valid=1 and cnt<MAX_COLS: write the column, cnt+1.
  - in_valid=1 and cnt==MAX_COLS: drop the column, set frame_ovf and ovf.
  - Score is re-latched on every valid cycle, so the frame carries the value from the last valid cycle.
  - in_valid=0: go to HDR_SCORE.
- Stored column entry: {q_sym, d_sym, match}, where match = !q_gap && !d_gap && (q_letter == d_letter).
- HDR_SCORE:
  - out_data = zero-extended score.
  - On handshake: go to HDR_LEN.
- HDR_LEN:
  - out_data = {frame_ovf, cnt[6:0]}.
  - On handshake: go to DRAIN and load the read index (cnt−1 if REVERSE, else 0).
- DRAIN:
  - out_data = {q_sym[2:0], d_sym[2:0], match, 1'b0}.
  - Each handshake steps the index (−1 if REVERSE, else +1).
  - out_last is high on the cnt-th column byte.
  - Handshake on the last byte: go to IDLE, clear frame_ovf.
- in_valid while not in IDLE/COLLECT (headers or DRAIN): the column is dropped and ovf is set. The frame in progress is unaffected.
- cnt is 7 bits and saturates at MAX_COLS. No wrap-around is permitted.
- Every frame has at least 1 column, because COLLECT is entered only on a valid column.

## Timing
- Reset values:
  - State IDLE, cnt=0, read index 0, frame_ovf=0.
  - out_valid=0, out_data=0x00, out_last=0, ovf=0, pk_ready=1.
  - Buffer contents are don't-care.
- Reset mid-operation: takes effect at the next edge. The partial frame is discarded, nothing is emitted, and ovf is cleared.
- Column write latency: a column presented in cycle k is stored at the end of cycle k.
- Output start latency: if the last in_valid is in cycle N, the state moves to HDR_SCORE at the end of N+1 and out_valid is first high in cycle N+2.
- out_data, out_valid and out_last are registered. They are held stable while out_valid && !out_ready.
- With out_ready tied high, one byte is emitted per cycle. A frame is cnt+2 bytes in cnt+2 consecutive cycles.
- pk_ready rises in the cycle after the final handshake. The next column may arrive in that same cycle.
- No combinational path from out_ready to out_valid or out_data.

## Test plan
- Reset: assert rst for 2 cycles.
  - Expect out_valid=0, out_data=0x00, out_last=0, pk_ready=1, ovf=0.
- Basic frame: REVERSE=1, out_ready=1, in_score=5. Columns (q,d) in order: (011,011), (100,010), (000,000).
  - Expect bytes 0x05, 0x03, 0x02, 0x88, 0x6E.
  - out_last is high only on 0x6E.
  - The first byte appears 2 cycles after the last in_valid.
- Backpressure: same input, out_ready pattern 1,0,0,1,0,1,….
  - Each byte is held stable while stalled.
  - Byte sequence is identical to the basic frame, with no skips or duplicates.
- Overflow: 70 consecutive valid columns, all (000,000).
  - Expect length byte 0xC0, exactly 64 column bytes of 0x02, ovf=1.
  - The next frame's length byte has bit7=0.
- Drop while busy: during DRAIN with out_ready=0, pulse in_valid for 3 cycles.
  - Expect ovf=1, the current frame completes unchanged, pk_ready=0 until its final handshake.
- Reset mid-DRAIN: assert rst after 2 column bytes.
  - Next cycle: out_valid=0, pk_ready=1, ovf=0.
  - The following alignment frames correctly.
